sync_fifo_thr: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 36 +++
 rtl/fifo_mem_2p.sv | 40 ++++
 rtl/sync_fifo_thr.sv | 166 ++++++++++++++++
 tb/tb_sync_fifo_thr.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the single-clock threshold FIFO:
//   - default parameter constants for sync_fifo_thr
//   - ptr_t / cnt_t typedefs sized for the default depth (Addr_Width+1 bits)
//   - helper functions deriving full/empty from a write/read pointer pair
// No ports (package).
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEF_DEPTH      = 256;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_AF_LEVEL   = 240;
    localparam int DEF_AE_LEVEL   = 16;
    localparam int DEF_FWFT       = 0;

    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;
    typedef logic [DEF_ADDR_WIDTH:0] cnt_t;

    // Pointers carry one extra wrap bit. Callers zero-extend them to 32 bits,
    // so "full" means the two pointers differ in exactly the wrap bit
    // (bit addrWidth) and agree on every address bit.
    function automatic logic ptrFull(input logic [31:0] wrPtr,
                                     input logic [31:0] rdPtr,
                                     input int          addrWidth);
        return ((wrPtr ^ rdPtr) == (32'd1 << addrWidth));
    endfunction

    // Empty whenever both pointers, including the wrap bit, are identical.
    function automatic logic ptrEmpty(input logic [31:0] wrPtr,
                                      input logic [31:0] rdPtr);
        return (wrPtr == rdPtr);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// ---------------------------------------------------------------------------
// fifo_mem_2p
// Depth x Data_Width register array used as FIFO storage.
// Ports:
//   i_clk     clock, write happens on posedge
//   i_wrEn    write enable
//   i_wrAddr  write address
//   i_wrData  write data
//   i_rdAddr  read address
//   o_rdData  asynchronous read data (combinational from i_rdAddr)
// Contents are never reset.
// ---------------------------------------------------------------------------
module fifo_mem_2p #(
    parameter int Depth      = 256,
    parameter int Data_Width = 8,
    parameter int Addr_Width = 8
) (
    input  logic                  i_clk,
    input  logic                  i_wrEn,
    input  logic [Addr_Width-1:0] i_wrAddr,
    input  logic [Data_Width-1:0] i_wrData,
    input  logic [Addr_Width-1:0] i_rdAddr,
    output logic [Data_Width-1:0] o_rdData
);

    logic [Data_Width-1:0] r_mem [Depth];

    // Synchronous write port; the top only asserts i_wrEn for accepted writes,
    // so a dropped write at full never disturbs stored data.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Asynchronous read port, which lets the top present the head word in
    // first-word-fall-through mode without an extra cycle.
    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/sync_fifo_thr.sv
// ---------------------------------------------------------------------------
// sync_fifo_thr
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   wr_en/data_in write request and data
//   rd_en         read request (pop in FWFT mode)
//   data_out      read data
//   full/empty    count == Depth / count == 0
//   almost_full   count >= AF_Level
//   almost_empty  count <= AE_Level
//   count         occupancy 0..Depth
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//   err_clr       clears the sticky flags (a new set in the same cycle wins)
// ---------------------------------------------------------------------------
module sync_fifo_thr
    import sync_fifo_pkg::*;
#(
    parameter int Depth      = DEF_DEPTH,
    parameter int Data_Width = DEF_DATA_WIDTH,
    parameter int Addr_Width = DEF_ADDR_WIDTH,
    parameter int AF_Level   = DEF_AF_LEVEL,
    parameter int AE_Level   = DEF_AE_LEVEL,
    parameter int FWFT       = DEF_FWFT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [Data_Width-1:0] data_in,
    input  logic                  rd_en,
    output logic [Data_Width-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [Addr_Width:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int CntW = Addr_Width + 1;
    localparam logic [CntW-1:0] AF_THR = CntW'(AF_Level);
    localparam logic [CntW-1:0] AE_THR = CntW'(AE_Level);
    localparam bit FWFT_MODE = (FWFT != 0);

    // Reject parameter sets that would break the pointer arithmetic or make
    // the thresholds meaningless.
    if (Depth < 4 || (Depth & (Depth - 1)) != 0) begin : gBadDepth
        $fatal(1, "sync_fifo_thr: Depth must be a power of two >= 4");
    end
    if (Addr_Width != $clog2(Depth)) begin : gBadAddrWidth
        $fatal(1, "sync_fifo_thr: Addr_Width must equal clog2(Depth)");
    end
    if (AE_Level < 0 || AE_Level >= AF_Level || AF_Level > Depth) begin : gBadLevels
        $fatal(1, "sync_fifo_thr: need 0 <= AE_Level < AF_Level <= Depth");
    end

    logic [CntW-1:0]       r_wrPtr;
    logic [CntW-1:0]       r_rdPtr;
    logic [CntW-1:0]       r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almostFull;
    logic                  r_almostEmpty;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [Data_Width-1:0] r_dataOut;

    logic                  w_wrFire;
    logic                  w_rdFire;
    logic [CntW-1:0]       w_wrPtrNext;
    logic [CntW-1:0]       w_rdPtrNext;
    logic [CntW-1:0]       w_countNext;
    logic                  w_fullNext;
    logic                  w_emptyNext;
    logic [Data_Width-1:0] w_memRdData;

    // Accept/reject decisions come from the registered flags only, so the
    // request-to-fire path never loops through the next-state logic.
    assign w_wrFire = wr_en & ~r_full;
    assign w_rdFire = rd_en & ~r_empty;

    // Next-state pointers and the flags they imply. Pointers wrap naturally
    // at 2*Depth because they are exactly Addr_Width+1 bits wide, and count
    // is their modular difference.
    always_comb begin
        w_wrPtrNext = r_wrPtr + CntW'(w_wrFire);
        w_rdPtrNext = r_rdPtr + CntW'(w_rdFire);
        w_countNext = w_wrPtrNext - w_rdPtrNext;
        w_fullNext  = ptrFull(32'(w_wrPtrNext), 32'(w_rdPtrNext), Addr_Width);
        w_emptyNext = ptrEmpty(32'(w_wrPtrNext), 32'(w_rdPtrNext));
    end

    fifo_mem_2p #(
        .Depth      (Depth),
        .Data_Width (Data_Width),
        .Addr_Width (Addr_Width)
    ) uMem (
        .i_clk    (clk),
        .i_wrEn   (w_wrFire),
        .i_wrAddr (r_wrPtr[Addr_Width-1:0]),
        .i_wrData (data_in),
        .i_rdAddr (r_rdPtr[Addr_Width-1:0]),
        .o_rdData (w_memRdData)
    );

    // Pointer, occupancy and threshold state. Every flag is registered from
    // the next-state values so it describes the FIFO after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
        end else begin
            r_wrPtr       <= w_wrPtrNext;
            r_rdPtr       <= w_rdPtrNext;
            r_count       <= w_countNext;
            r_full        <= w_fullNext;
            r_empty       <= w_emptyNext;
            r_almostFull  <= (w_countNext >= AF_THR);
            r_almostEmpty <= (w_countNext <= AE_THR);
        end
    end

    // Sticky error flags. A fresh violation in the same cycle as err_clr
    // keeps the flag set so no event is ever silently lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (wr_en & r_full)  | (r_overflow  & ~err_clr);
            r_underflow <= (rd_en & r_empty) | (r_underflow & ~err_clr);
        end
    end

    // Registered read data for standard mode: the popped word is captured on
    // the accepted read and held otherwise. In FWFT mode this register just
    // keeps its reset value and serves as the idle output while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dataOut <= '0;
        end else if (!FWFT_MODE && w_rdFire) begin
            r_dataOut <= w_memRdData;
        end
    end

    // In FWFT mode the head word is shown straight from the async read port
    // whenever something is stored.
    assign data_out     = (FWFT_MODE && !r_empty) ? w_memRdData : r_dataOut;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almostFull;
    assign almost_empty = r_almostEmpty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_thr.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_thr
// Directed bench for sync_fifo_thr with Depth=16, AF_Level=14, AE_Level=2.
// One instance runs in standard mode, a second in first-word-fall-through.
// ---------------------------------------------------------------------------
module tb_sync_fifo_thr;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          wrEn = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic          rdEn = 1'b0;
    logic          errClr = 1'b0;
    logic [DW-1:0] dataOut;
    logic          full, empty, almostFull, almostEmpty, overflow, underflow;
    logic [AW:0]   count;

    logic          wrEnF = 1'b0;
    logic [DW-1:0] dataInF = '0;
    logic          rdEnF = 1'b0;
    logic          errClrF = 1'b0;
    logic [DW-1:0] dataOutF;
    logic          fullF, emptyF, almostFullF, almostEmptyF, overflowF, underflowF;
    logic [AW:0]   countF;

    int testCount = 0;
    int failCount = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    sync_fifo_thr #(
        .Depth(DEPTH), .Data_Width(DW), .Addr_Width(AW),
        .AF_Level(14), .AE_Level(2), .FWFT(0)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wrEn), .data_in(dataIn), .rd_en(rdEn),
        .data_out(dataOut), .full(full), .empty(empty),
        .almost_full(almostFull), .almost_empty(almostEmpty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(errClr)
    );

    sync_fifo_thr #(
        .Depth(DEPTH), .Data_Width(DW), .Addr_Width(AW),
        .AF_Level(14), .AE_Level(2), .FWFT(1)
    ) dutF (
        .clk(clk), .rst(rst), .wr_en(wrEnF), .data_in(dataInF), .rd_en(rdEnF),
        .data_out(dataOutF), .full(fullF), .empty(emptyF),
        .almost_full(almostFullF), .almost_empty(almostEmptyF), .count(countF),
        .overflow(overflowF), .underflow(underflowF), .err_clr(errClrF)
    );

    // Drive one cycle of inputs to the selected instance (0 = standard,
    // 1 = FWFT), let one rising edge pass, then settle 1 unit past the edge.
    task automatic applyStimulus(input bit sel, input logic wr, input logic [DW-1:0] din,
                                 input logic rd, input logic clr);
        wrEn    = sel ? 1'b0 : wr;
        dataIn  = sel ? '0   : din;
        rdEn    = sel ? 1'b0 : rd;
        errClr  = sel ? 1'b0 : clr;
        wrEnF   = sel ? wr   : 1'b0;
        dataInF = sel ? din  : '0;
        rdEnF   = sel ? rd   : 1'b0;
        errClrF = sel ? clr  : 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset held for two edges.
        rst = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        rst = 1'b0;
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_aempty", 32'(almostEmpty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_afull", 32'(almostFull), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_dout", 32'(dataOut), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_unf", 32'(underflow), 32'd0);
        checkOutput("rst_emptyF", 32'(emptyF), 32'd1);

        // Fill 0x00..0x0F, thresholds tracked on every step.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 8'(i), 0, 0);
            checkOutput("fill_count", 32'(count), 32'(i + 1));
            checkOutput("fill_aempty", 32'(almostEmpty), 32'((i + 1) <= 2));
            checkOutput("fill_afull", 32'(almostFull), 32'((i + 1) >= 14));
            checkOutput("fill_full", 32'(full), 32'((i + 1) == 16));
            checkOutput("fill_empty", 32'(empty), 32'd0);
        end

        // 17th write is dropped and flagged.
        applyStimulus(0, 1, 8'hAA, 0, 0);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(count), 32'd16);
        checkOutput("ovf_full", 32'(full), 32'd1);

        // Drain in order.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 8'h00, 1, 0);
            checkOutput("drain_dout", 32'(dataOut), 32'(i));
            checkOutput("drain_count", 32'(count), 32'(15 - i));
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Prefill 5 words, then 20 cycles of simultaneous write+read.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 8'(8'h20 + i), 0, 0);
        end
        checkOutput("sim_pre_count", 32'(count), 32'd5);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 1, 8'(8'h30 + k), 1, 0);
            checkOutput("sim_count", 32'(count), 32'd5);
            checkOutput("sim_dout", 32'(dataOut),
                        (k < 5) ? 32'(8'h20 + k) : 32'(8'h30 + k - 5));
        end
        for (int j = 0; j < 5; j++) begin
            applyStimulus(0, 0, 8'h00, 1, 0);
            checkOutput("sim_tail_dout", 32'(dataOut), 32'(8'h3F + j));
            checkOutput("sim_tail_count", 32'(count), 32'(4 - j));
        end
        checkOutput("sim_empty", 32'(empty), 32'd1);

        // Underflow: read from empty, then clear-vs-set priority.
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("unf_flag", 32'(underflow), 32'd1);
        checkOutput("unf_dout_hold", 32'(dataOut), 32'h43);
        checkOutput("unf_count", 32'(count), 32'd0);
        applyStimulus(0, 0, 8'h00, 1, 1);
        checkOutput("unf_set_wins", 32'(underflow), 32'd1);
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("unf_cleared", 32'(underflow), 32'd0);

        // FWFT instance: head word visible one cycle after the write.
        applyStimulus(1, 1, 8'h5A, 0, 0);
        checkOutput("fwft_dout", 32'(dataOutF), 32'h5A);
        checkOutput("fwft_empty", 32'(emptyF), 32'd0);
        checkOutput("fwft_count", 32'(countF), 32'd1);
        applyStimulus(1, 0, 8'h00, 0, 0);
        checkOutput("fwft_dout_hold", 32'(dataOutF), 32'h5A);
        applyStimulus(1, 0, 8'h00, 1, 0);
        checkOutput("fwft_pop_empty", 32'(emptyF), 32'd1);
        checkOutput("fwft_pop_unf", 32'(underflowF), 32'd0);

        // Reset in the middle of operation discards the stored words.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 1, 8'(8'h60 + i), 0, 0);
        end
        checkOutput("mid_pre_count", 32'(count), 32'd9);
        rst = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 0);
        rst = 1'b0;
        checkOutput("mid_count", 32'(count), 32'd0);
        checkOutput("mid_empty", 32'(empty), 32'd1);
        checkOutput("mid_aempty", 32'(almostEmpty), 32'd1);
        checkOutput("mid_dout", 32'(dataOut), 32'd0);
        applyStimulus(0, 1, 8'h77, 0, 0);
        checkOutput("mid_wr_count", 32'(count), 32'd1);
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("mid_rd_dout", 32'(dataOut), 32'h77);
        checkOutput("mid_rd_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
